seg_scan_decoder: RTL and testbench



---
 rtl/seg_scan_pkg.sv | 51 +++++
 rtl/seg7_pattern_decode.sv | 36 +++
 rtl/seg_scan_decoder.sv | 202 ++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan decoder.
package seg_scan_pkg;

    typedef logic [4:0] digit_code_t;

    localparam digit_code_t CODE_BLANK = 5'h10;
    localparam digit_code_t CODE_MINUS = 5'h11;
    localparam digit_code_t CODE_UNK   = 5'h1F;

    // Segment patterns, bit order g..a (bit0 = a).
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;

    // One decoded 8-digit frame: digit i code in code[5i+4:5i], dp in dp[i].
    typedef struct packed {
        logic [7:0]  dp;
        logic [39:0] code;
    } frame_t;

    localparam frame_t FRAME_RESET = '{dp: 8'h00, code: {8{CODE_BLANK}}};

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

    function automatic logic [2:0] onehot_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational map from a 7-bit segment pattern back to a symbol code.
module seg7_pattern_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0]  pattern_i,
    output digit_code_t code_o
);

    // Pattern lookup; anything outside the symbol set reads as UNK.
    always_comb begin
        // NOTE: default first so every path assigns code_o and no latch is inferred.
        code_o = CODE_UNK;
        case (pattern_i)
            SEG_0:     code_o = 5'h00;
            SEG_1:     code_o = 5'h01;
            SEG_2:     code_o = 5'h02;
            SEG_3:     code_o = 5'h03;
            SEG_4:     code_o = 5'h04;
            SEG_5:     code_o = 5'h05;
            SEG_6:     code_o = 5'h06;
            SEG_7:     code_o = 5'h07;
            SEG_8:     code_o = 5'h08;
            SEG_9:     code_o = 5'h09;
            SEG_A:     code_o = 5'h0A;
            SEG_B:     code_o = 5'h0B;
            SEG_C:     code_o = 5'h0C;
            SEG_D:     code_o = 5'h0D;
            SEG_E:     code_o = 5'h0E;
            SEG_F:     code_o = 5'h0F;
            SEG_BLANK: code_o = CODE_BLANK;
            SEG_MINUS: code_o = CODE_MINUS;
            default:   code_o = CODE_UNK;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Watches a multiplexed 8-digit seven-segment scan, rebuilds whole frames
// and publishes each new stable frame over a valid/ready handshake.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int unsigned SETTLE         = 4,
    parameter int unsigned STABLE_FRAMES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  an,
    input  logic [7:0]  duan,
    input  logic [7:0]  duan1,
    output logic [39:0] frame_code,
    output logic [7:0]  frame_dp,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        overrun,
    output logic        scan_err,
    output logic        stale
);

    localparam int unsigned SCNT_W = $clog2(SETTLE + 1);
    localparam int unsigned MCNT_W = $clog2(STABLE_FRAMES + 1);
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SCNT_W-1:0] SETTLE_MAX   = SCNT_W'(SETTLE);
    localparam logic [MCNT_W-1:0] MATCH_MAX    = MCNT_W'(STABLE_FRAMES);
    localparam logic [TCNT_W-1:0] TIMEOUT_MAX  = TCNT_W'(TIMEOUT_CYCLES);
    localparam logic [TCNT_W-1:0] TIMEOUT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    // Two-stage synchroniser for the 24 pad inputs.
    logic [23:0] sync_meta_q, sync_q;
    logic [7:0]  an_s, duan_s, duan1_s;

    // Synchroniser flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_q <= '0;
            sync_q      <= '0;
        end else begin
            // NOTE: non-blocking so each stage takes the previous stage's old value.
            sync_meta_q <= {duan1, duan, an};
            sync_q      <= sync_meta_q;
        end
    end

    assign an_s    = sync_q[7:0];
    assign duan_s  = sync_q[15:8];
    assign duan1_s = sync_q[23:16];

    // Dwell tracking: settle_q counts cycles the current select has been
    // steady, with the change cycle itself counted as the first.
    logic [7:0]        an_prev_q;
    logic [SCNT_W-1:0] settle_q, settle_d;
    logic              an_chg, an_onehot, an_multi, capture, scan_err_q;
    logic [2:0]        cap_idx;
    logic [7:0]        seg_sel;
    digit_code_t       cap_code;

    assign an_chg    = (an_s != an_prev_q);
    assign an_onehot = is_onehot(an_s);
    assign an_multi  = (an_s != 8'h00) && !an_onehot;
    assign cap_idx   = onehot_idx(an_s);
    assign seg_sel   = cap_idx[2] ? duan1_s : duan_s;

    // Settle count and the single capture strobe per qualifying dwell.
    always_comb begin
        settle_d = settle_q;
        capture  = 1'b0;
        if (an_chg) begin
            settle_d = SCNT_W'(1);
        end else if (settle_q != SETTLE_MAX) begin
            settle_d = settle_q + 1'b1;
        end
        capture = an_onehot && (settle_d == SETTLE_MAX) && (an_chg || settle_q != SETTLE_MAX);
    end

    seg7_pattern_decode u_decode (
        .pattern_i (seg_sel[6:0]),
        .code_o    (cap_code)
    );

    // Frame assembly, stability matching and stale tracking.
    frame_t            work_q, work_d, prev_q, prev_d, pub_q, pub_d;
    logic [7:0]        seen_q, seen_d;
    logic [MCNT_W-1:0] match_q, match_d;
    logic [TCNT_W-1:0] timer_q, timer_d;
    logic              cmp_done_q, cmp_done_d, stale_q, stale_d;
    logic              valid_q, valid_d, overrun_q, overrun_d, pub_any_q, pub_any_d;
    logic              qualify;

    // Next state for the working buffer, previous frame and stale timer.
    always_comb begin
        work_d     = work_q;
        prev_d     = prev_q;
        seen_d     = seen_q;
        match_d    = match_q;
        timer_d    = timer_q;
        stale_d    = stale_q;
        cmp_done_d = 1'b0;

        if (seen_q == 8'hFF) begin
            cmp_done_d = 1'b1;
            seen_d     = 8'h00;
            prev_d     = work_q;
            if (work_q == prev_q) begin
                match_d = (match_q == MATCH_MAX) ? match_q : match_q + 1'b1;
            end else begin
                match_d = MCNT_W'(1);
            end
        end

        if (capture) begin
            timer_d = '0;
        end else if (timer_q != TIMEOUT_MAX) begin
            timer_d = timer_q + 1'b1;
        end

        if (!capture && timer_q == TIMEOUT_LAST) begin
            stale_d = 1'b1;
            seen_d  = 8'h00;
            match_d = '0;
            prev_d  = '0;
        end

        if (capture) begin
            stale_d                             = 1'b0;
            seen_d[cap_idx]                     = 1'b1;
            work_d.code[5*int'(cap_idx) +: 5]   = cap_code;
            work_d.dp[cap_idx]                  = seg_sel[7];
        end
    end

    // A just-compared frame publishes once it is stable and new to the consumer.
    assign qualify = cmp_done_q && (match_q == MATCH_MAX) && (!pub_any_q || prev_q != pub_q);

    // Handshake: accept first, then load or record an overrun.
    always_comb begin
        pub_d     = pub_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        pub_any_d = pub_any_q;
        if (valid_q && frame_ready) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
        if (qualify) begin
            if (!valid_d) begin
                pub_d     = prev_q;
                valid_d   = 1'b1;
                pub_any_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State registers for scan tracking, buffers and handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: buffers are reset too, so a partial frame disappears with reset.
            an_prev_q  <= 8'h00;
            settle_q   <= '0;
            scan_err_q <= 1'b0;
            work_q     <= '0;
            prev_q     <= '0;
            seen_q     <= 8'h00;
            match_q    <= '0;
            timer_q    <= '0;
            cmp_done_q <= 1'b0;
            stale_q    <= 1'b0;
            pub_q      <= FRAME_RESET;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            pub_any_q  <= 1'b0;
        end else begin
            an_prev_q  <= an_s;
            settle_q   <= settle_d;
            scan_err_q <= an_chg && an_multi;
            work_q     <= work_d;
            prev_q     <= prev_d;
            seen_q     <= seen_d;
            match_q    <= match_d;
            timer_q    <= timer_d;
            cmp_done_q <= cmp_done_d;
            stale_q    <= stale_d;
            pub_q      <= pub_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            pub_any_q  <= pub_any_d;
        end
    end

    assign frame_code  = pub_q.code;
    assign frame_dp    = pub_q.dp;
    assign frame_valid = valid_q;
    assign overrun     = overrun_q;
    assign scan_err    = scan_err_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans known displays and checks
// what gets published through the handshake.
module tb_seg_scan_decoder;

    localparam int SETTLE  = 4;
    localparam int STABLE  = 2;
    localparam int TIMEOUT = 2000;
    localparam int DWELL   = 100;

    // Segment bytes per digit, digit 7 leftmost in the literal.
    localparam logic [63:0] SEGS_A = {8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06};
    localparam logic [39:0] CODE_A = {5'h08, 5'h07, 5'h06, 5'h05, 5'h04, 5'h03, 5'h02, 5'h01};
    localparam logic [63:0] SEGS_C = {8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F};
    localparam logic [39:0] CODE_C = {5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08};
    localparam logic [63:0] SEGS_B = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'hBF, 8'h6D};
    localparam logic [39:0] CODE_B = {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h11, 5'h00, 5'h05};
    localparam logic [63:0] SEGS_E = {8'h07, 8'h7D, 8'h6D, 8'hE6, 8'h4F, 8'h5B, 8'h06, 8'h3F};
    localparam logic [39:0] CODE_E = {5'h07, 5'h06, 5'h05, 5'h04, 5'h03, 5'h02, 5'h01, 5'h00};
    localparam logic [63:0] SEGS_F = {8'h6F, 8'h71, 8'h79, 8'h5E, 8'h2A, 8'h39, 8'h7C, 8'h77};
    localparam logic [39:0] CODE_F = {5'h09, 5'h0F, 5'h0E, 5'h0D, 5'h1F, 5'h0C, 5'h0B, 5'h0A};
    localparam logic [63:0] SEGS_G = {8'h7F, 8'hFF, 8'h7F, 8'hFF, 8'h7F, 8'hFF, 8'h7F, 8'hFF};
    localparam logic [39:0] CODE_G = {8{5'h08}};
    localparam logic [63:0] SEGS_H = {8'h66, 8'h4F, 8'h4F, 8'h4F, 8'h4F, 8'h4F, 8'h4F, 8'h4F};
    localparam logic [39:0] CODE_H = {5'h04, 5'h03, 5'h03, 5'h03, 5'h03, 5'h03, 5'h03, 5'h03};
    localparam logic [39:0] BLANKS = {8{5'h10}};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  an = 8'h00;
    logic [7:0]  duan = 8'h00;
    logic [7:0]  duan1 = 8'h00;
    logic        frame_ready = 1'b0;
    logic [39:0] frame_code;
    logic [7:0]  frame_dp;
    logic        frame_valid, overrun, scan_err, stale;

    int n_checks = 0;
    int n_errors = 0;
    int acc_cnt = 0;
    int err_pulses = 0;
    logic [39:0] acc_code = '0;
    logic [7:0]  acc_dp = '0;

    always #5 clk = ~clk;

    seg_scan_decoder #(
        .SETTLE         (SETTLE),
        .STABLE_FRAMES  (STABLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an),
        .duan        (duan),
        .duan1       (duan1),
        .frame_code  (frame_code),
        .frame_dp    (frame_dp),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .overrun     (overrun),
        .scan_err    (scan_err),
        .stale       (stale)
    );

    // Record every accepted frame and every scan_err cycle.
    always @(posedge clk) begin
        if (frame_valid && frame_ready) begin
            acc_cnt  <= acc_cnt + 1;
            acc_code <= frame_code;
            acc_dp   <= frame_dp;
        end
        if (scan_err) err_pulses <= err_pulses + 1;
    end

    task automatic drive_digit(input int i, input logic [7:0] seg, input int cycles);
        an    = 8'(1 << i);
        duan  = (i < 4) ? seg : 8'h00;
        duan1 = (i < 4) ? 8'h00 : seg;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic scan_digits(input logic [63:0] segs, input int first, input int last);
        for (int i = first; i <= last; i++) drive_digit(i, segs[8*i +: 8], DWELL);
    endtask

    task automatic scan_frame(input logic [63:0] segs);
        scan_digits(segs, 0, 7);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (frame_code !== BLANKS) begin n_errors++; $display("FAIL reset_code: got %h expected %h", frame_code, BLANKS); end
        n_checks++; if (frame_dp !== 8'h00) begin n_errors++; $display("FAIL reset_dp: got %h expected 00", frame_dp); end
        n_checks++; if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", frame_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        n_checks++; if (scan_err !== 1'b0) begin n_errors++; $display("FAIL reset_scan_err: got %b expected 0", scan_err); end
        n_checks++; if (stale !== 1'b0) begin n_errors++; $display("FAIL reset_stale: got %b expected 0", stale); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        int base;
        base = acc_cnt;
        frame_ready = 1'b1;
        scan_frame(SEGS_A);
        n_checks++; if (acc_cnt !== base) begin n_errors++; $display("FAIL nominal_early: got %0d accepts expected %0d", acc_cnt, base); end
        scan_frame(SEGS_A);
        n_checks++; if (acc_cnt !== base + 1) begin n_errors++; $display("FAIL nominal_publish: got %0d accepts expected %0d", acc_cnt, base + 1); end
        n_checks++; if (acc_code !== CODE_A) begin n_errors++; $display("FAIL nominal_code: got %h expected %h", acc_code, CODE_A); end
        n_checks++; if (acc_dp !== 8'h00) begin n_errors++; $display("FAIL nominal_dp: got %h expected 00", acc_dp); end
        n_checks++; if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL nominal_valid_drop: got %b expected 0", frame_valid); end
        scan_frame(SEGS_A);
        scan_frame(SEGS_A);
        n_checks++; if (acc_cnt !== base + 1) begin n_errors++; $display("FAIL nominal_no_repeat: got %0d accepts expected %0d", acc_cnt, base + 1); end
    endtask

    task automatic test_backpressure();
        int base;
        base = acc_cnt;
        frame_ready = 1'b0;
        scan_frame(SEGS_C);
        scan_frame(SEGS_C);
        n_checks++; if (frame_valid !== 1'b1) begin n_errors++; $display("FAIL bp_valid: got %b expected 1", frame_valid); end
        n_checks++; if (frame_code !== CODE_C) begin n_errors++; $display("FAIL bp_first_code: got %h expected %h", frame_code, CODE_C); end
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL bp_no_overrun_yet: got %b expected 0", overrun); end
        scan_frame(SEGS_B);
        scan_frame(SEGS_B);
        n_checks++; if (overrun !== 1'b1) begin n_errors++; $display("FAIL bp_overrun: got %b expected 1", overrun); end
        n_checks++; if (frame_code !== CODE_C) begin n_errors++; $display("FAIL bp_held_code: got %h expected %h", frame_code, CODE_C); end
        n_checks++; if (acc_cnt !== base) begin n_errors++; $display("FAIL bp_no_accept: got %0d accepts expected %0d", acc_cnt, base); end
        frame_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (acc_cnt !== base + 1 || acc_code !== CODE_C) begin n_errors++; $display("FAIL bp_accept: got %0d/%h expected %0d/%h", acc_cnt, acc_code, base + 1, CODE_C); end
        n_checks++; if (overrun !== 1'b0) begin n_errors++; $display("FAIL bp_overrun_clear: got %b expected 0", overrun); end
        n_checks++; if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL bp_valid_clear: got %b expected 0", frame_valid); end
        scan_frame(SEGS_B);
        n_checks++; if (acc_cnt !== base + 2) begin n_errors++; $display("FAIL bp_second_publish: got %0d accepts expected %0d", acc_cnt, base + 2); end
        n_checks++; if (acc_code !== CODE_B) begin n_errors++; $display("FAIL bp_second_code: got %h expected %h", acc_code, CODE_B); end
        n_checks++; if (acc_dp !== 8'h02) begin n_errors++; $display("FAIL bp_second_dp: got %h expected 02", acc_dp); end
    endtask

    task automatic test_glitch();
        int base, pulses0;
        logic [63:0] segs;
        segs = SEGS_E;
        base = acc_cnt;
        scan_frame(segs);
        scan_digits(segs, 0, 3);
        pulses0 = err_pulses;
        an = 8'h03; duan = 8'h7F; duan1 = 8'h00;
        repeat (20) @(negedge clk);
        drive_digit(4, segs[39:32], SETTLE - 1);
        scan_digits(segs, 5, 7);
        n_checks++; if (err_pulses !== pulses0 + 1) begin n_errors++; $display("FAIL glitch_scan_err: got %0d pulses expected %0d", err_pulses - pulses0, 1); end
        n_checks++; if (acc_cnt !== base) begin n_errors++; $display("FAIL glitch_no_sample: got %0d accepts expected %0d", acc_cnt, base); end
        drive_digit(4, segs[39:32], DWELL);
        n_checks++; if (acc_cnt !== base + 1) begin n_errors++; $display("FAIL glitch_complete: got %0d accepts expected %0d", acc_cnt, base + 1); end
        n_checks++; if (acc_code !== CODE_E) begin n_errors++; $display("FAIL glitch_code: got %h expected %h", acc_code, CODE_E); end
        n_checks++; if (acc_dp !== 8'h10) begin n_errors++; $display("FAIL glitch_dp: got %h expected 10", acc_dp); end
    endtask

    task automatic test_unknown();
        int base;
        base = acc_cnt;
        scan_frame(SEGS_F);
        scan_frame(SEGS_F);
        n_checks++; if (acc_cnt !== base + 1) begin n_errors++; $display("FAIL unknown_publish: got %0d accepts expected %0d", acc_cnt, base + 1); end
        n_checks++; if (acc_code !== CODE_F) begin n_errors++; $display("FAIL unknown_code: got %h expected %h", acc_code, CODE_F); end
    endtask

    task automatic test_stale();
        int base;
        base = acc_cnt;
        scan_frame(SEGS_G);
        n_checks++; if (acc_cnt !== base) begin n_errors++; $display("FAIL stale_pre_publish: got %0d accepts expected %0d", acc_cnt, base); end
        an = 8'h00; duan = 8'h00; duan1 = 8'h00;
        repeat (TIMEOUT - 300) @(negedge clk);
        n_checks++; if (stale !== 1'b0) begin n_errors++; $display("FAIL stale_early: got %b expected 0", stale); end
        repeat (400) @(negedge clk);
        n_checks++; if (stale !== 1'b1) begin n_errors++; $display("FAIL stale_set: got %b expected 1", stale); end
        n_checks++; if (frame_code !== CODE_F) begin n_errors++; $display("FAIL stale_outputs_kept: got %h expected %h", frame_code, CODE_F); end
        scan_digits(SEGS_G, 0, 0);
        n_checks++; if (stale !== 1'b0) begin n_errors++; $display("FAIL stale_clear: got %b expected 0", stale); end
        scan_digits(SEGS_G, 1, 7);
        n_checks++; if (acc_cnt !== base) begin n_errors++; $display("FAIL stale_match_cleared: got %0d accepts expected %0d", acc_cnt, base); end
        scan_frame(SEGS_G);
        n_checks++; if (acc_cnt !== base + 1 || acc_code !== CODE_G) begin n_errors++; $display("FAIL stale_republish: got %0d/%h expected %0d/%h", acc_cnt, acc_code, base + 1, CODE_G); end
        n_checks++; if (acc_dp !== 8'h55) begin n_errors++; $display("FAIL stale_republish_dp: got %h expected 55", acc_dp); end
    endtask

    task automatic test_reset_mid();
        int base;
        base = acc_cnt;
        scan_digits(SEGS_H, 0, 4);
        rst_n = 1'b0;
        an = 8'h00; duan = 8'h00; duan1 = 8'h00;
        #1;
        n_checks++; if (frame_code !== BLANKS) begin n_errors++; $display("FAIL rst_mid_code: got %h expected %h", frame_code, BLANKS); end
        n_checks++; if (frame_dp !== 8'h00) begin n_errors++; $display("FAIL rst_mid_dp: got %h expected 00", frame_dp); end
        n_checks++; if (frame_valid !== 1'b0 || overrun !== 1'b0 || stale !== 1'b0) begin n_errors++; $display("FAIL rst_mid_flags: got valid=%b overrun=%b stale=%b expected 0/0/0", frame_valid, overrun, stale); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        scan_digits(SEGS_H, 5, 7);
        scan_frame(SEGS_H);
        n_checks++; if (acc_cnt !== base) begin n_errors++; $display("FAIL rst_mid_discard: got %0d accepts expected %0d", acc_cnt, base); end
        scan_frame(SEGS_H);
        n_checks++; if (acc_cnt !== base + 1 || acc_code !== CODE_H) begin n_errors++; $display("FAIL rst_mid_publish: got %0d/%h expected %0d/%h", acc_cnt, acc_code, base + 1, CODE_H); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_glitch();
        test_unknown();
        test_stale();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
